// File: rtl/llmint8_pkg.sv
// Shared definitions for the int8 block quantization datapath.
// Holds the int8 clamp limit, the reciprocal quotient width derivation and
// the quantizer FSM state encoding.
package llmint8_pkg;

  // Largest magnitude an int8 lane may carry; -128 is deliberately unused so
  // the code range is symmetric.
  localparam int INT8_QMAX      = 127;
  localparam int INT8_QMAX_BITS = $clog2(INT8_QMAX + 1);

  // Integer bits of 127/max plus the fractional bits of the reciprocal.
  function automatic int div_width(input int frac_width);
    return INT8_QMAX_BITS + frac_width;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    MUL,
    OUT
  } quant_state_t;

endpackage

// File: rtl/seq_restoring_divider.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle, MSB first.
// Latency: DIVIDEND_WIDTH cycles after i_start; o_done is high during the last step.
// Backpressure: none; i_start is accepted whenever asserted and restarts the divider.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   i_start         load i_dividend / i_divisor and begin dividing
//   i_dividend      numerator (DIVIDEND_WIDTH bits)
//   i_divisor       denominator (DIVISOR_WIDTH bits, must be nonzero)
//   o_busy          division in progress
//   o_done          the final quotient bit is written on this clock edge
//   o_quotient      floor(dividend/divisor), valid the cycle after o_done
module seq_restoring_divider #(
  parameter int DIVIDEND_WIDTH = 23,
  parameter int DIVISOR_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [DIVIDEND_WIDTH-1:0] i_dividend,
  input  logic [DIVISOR_WIDTH-1:0]  i_divisor,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [DIVIDEND_WIDTH-1:0] o_quotient
);

  localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);

  logic [DIVISOR_WIDTH-1:0]  r_rem;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [DIVIDEND_WIDTH-1:0] r_quo;
  logic [DIVISOR_WIDTH-1:0]  r_div;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_busy;

  logic [DIVISOR_WIDTH:0]    w_trial;
  logic [DIVISOR_WIDTH:0]    w_diff;
  logic                      w_ge;
  logic [DIVISOR_WIDTH-1:0]  w_rem_next;

  // The remainder stays below the divisor, so the shifted trial value needs
  // only one extra bit and the restored remainder always fits DIVISOR_WIDTH.
  assign w_trial    = {r_rem, r_quo[DIVIDEND_WIDTH-1]};
  assign w_ge       = (w_trial >= {1'b0, r_div});
  assign w_diff     = w_trial - {1'b0, r_div};
  assign w_rem_next = w_ge ? w_diff[DIVISOR_WIDTH-1:0] : w_trial[DIVISOR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_div  <= i_divisor;
      r_cnt  <= CNT_W'(DIVIDEND_WIDTH);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= w_rem_next;
      r_quo <= {r_quo[DIVIDEND_WIDTH-2:0], w_ge};
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_busy && (r_cnt == CNT_W'(1));
  assign o_quotient = r_quo;

endmodule

// File: rtl/int8_block_quantizer.sv
// Block int8 quantizer: scale = 127/max_num via sequential divider, then N parallel
//   multiply-round-saturate lanes; emits int8 block plus max_num for dequant.
// Latency: valid DIV_WIDTH+2 cycles after input handshake (2 if max_num==0); one block in flight.
// Backpressure: outputs held until data_out_ready; data_in_ready returns the cycle after.
//
// Build option: define INT8_QUANT_ROUND_NEAREST_EN to round half away from zero;
// otherwise lanes truncate toward zero. Saturation and timing are the same in both.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   data_in, max_num                signed block elements and unsigned abs-max
//   data_in_valid / data_in_ready   input handshake
//   data_out, scale_out             int8 results and pass-through max_num
//   data_out_valid / data_out_ready output handshake
module int8_block_quantizer
  import llmint8_pkg::*;
#(
  parameter int IN_WIDTH       = 16,
  parameter int IN_SIZE        = 4,
  parameter int IN_PARALLELISM = 1,
  parameter int FRAC_WIDTH     = 16,
  parameter int OUT_WIDTH      = 8
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [IN_SIZE*IN_PARALLELISM-1:0][IN_WIDTH-1:0]     data_in,
  input  logic [IN_WIDTH-1:0]                                 max_num,
  input  logic                                                data_in_valid,
  output logic                                                data_in_ready,
  output logic [IN_SIZE*IN_PARALLELISM-1:0][OUT_WIDTH-1:0]    data_out,
  output logic [IN_WIDTH-1:0]                                 scale_out,
  output logic                                                data_out_valid,
  input  logic                                                data_out_ready
);

  localparam int N          = IN_SIZE * IN_PARALLELISM;
  localparam int DIV_WIDTH  = div_width(FRAC_WIDTH);
  localparam int PROD_WIDTH = IN_WIDTH + DIV_WIDTH + 1;

  // 127 in fixed point with FRAC_WIDTH fractional bits.
  localparam logic [DIV_WIDTH-1:0] DIV_DIVIDEND = DIV_WIDTH'(INT8_QMAX) << FRAC_WIDTH;

  quant_state_t                          r_state;
  logic [N-1:0][IN_WIDTH-1:0]            r_data;
  logic [IN_WIDTH-1:0]                   r_max;
  logic [N-1:0][OUT_WIDTH-1:0]           r_data_out;
  logic [IN_WIDTH-1:0]                   r_scale_out;
  logic                                  r_out_valid;
  logic                                  r_in_ready;

  logic                                  w_in_fire;
  logic                                  w_div_start;
  logic                                  w_div_busy;
  logic                                  w_div_done;
  logic [DIV_WIDTH-1:0]                  w_div_quo;
  logic [DIV_WIDTH-1:0]                  w_recip;
  logic [N-1:0][OUT_WIDTH-1:0]           w_lane_q;

  // r_in_ready is only ever high in IDLE, so the handshake alone implies IDLE.
  assign w_in_fire   = data_in_valid && r_in_ready;
  assign w_div_start = w_in_fire && (max_num != '0);

  seq_restoring_divider #(
    .DIVIDEND_WIDTH (DIV_WIDTH),
    .DIVISOR_WIDTH  (IN_WIDTH)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (DIV_DIVIDEND),
    .i_divisor  (max_num),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_div_quo)
  );

  // An all-zero block skips the divider, whose quotient still holds the
  // previous block's value, so force the reciprocal to zero here.
  assign w_recip = (r_max == '0) ? '0 : w_div_quo;

  // One lane: sign-magnitude scaling so rounding/truncation is symmetric about zero.
  function automatic logic [OUT_WIDTH-1:0] quant_lane(
    input logic signed [IN_WIDTH-1:0] x,
    input logic        [DIV_WIDTH-1:0] recip
  );
    logic signed [PROD_WIDTH-1:0] xe;
    logic signed [PROD_WIDTH-1:0] re;
    logic signed [PROD_WIDTH-1:0] p;
    logic        [PROD_WIDTH-1:0] mag;
    logic        [PROD_WIDTH-1:0] scaled;
    logic        [OUT_WIDTH-1:0]  sat;
    xe  = PROD_WIDTH'(x);
    re  = PROD_WIDTH'($signed({1'b0, recip}));
    p   = xe * re;
    mag = p[PROD_WIDTH-1] ? -p : p;
`ifdef INT8_QUANT_ROUND_NEAREST_EN
    scaled = (mag + (PROD_WIDTH'(1) << (FRAC_WIDTH - 1))) >> FRAC_WIDTH;
`else
    scaled = mag >> FRAC_WIDTH;
`endif
    // Clamp the magnitude before reapplying the sign so -128 cannot appear.
    if (scaled > PROD_WIDTH'(INT8_QMAX)) begin
      sat = OUT_WIDTH'(INT8_QMAX);
    end else begin
      sat = scaled[OUT_WIDTH-1:0];
    end
    return p[PROD_WIDTH-1] ? -sat : sat;
  endfunction

  always_comb begin
    w_lane_q = '0;
    for (int i = 0; i < N; i++) begin
      w_lane_q[i] = quant_lane(r_data[i], w_recip);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_max       <= '0;
      r_data_out  <= '0;
      r_scale_out <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            r_data     <= data_in;
            r_max      <= max_num;
            r_in_ready <= 1'b0;
            r_state    <= (max_num == '0) ? MUL : DIV;
          end
        end
        DIV: begin
          // The idle-divider escape keeps the FSM from stalling if the
          // divider was ever left stopped while we are in DIV.
          if (w_div_done || !w_div_busy) begin
            r_state <= MUL;
          end
        end
        MUL: begin
          r_data_out  <= w_lane_q;
          r_scale_out <= r_max;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (data_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign data_in_ready  = r_in_ready;
  assign data_out       = r_data_out;
  assign scale_out      = r_scale_out;
  assign data_out_valid = r_out_valid;

endmodule

// File: tb/tb_int8_block_quantizer.sv
// Self-checking bench for int8_block_quantizer: directed table, backpressure,
// mid-division reset and randomized blocks against an arithmetic reference.
module tb_int8_block_quantizer;

  localparam int IW = 16;
  localparam int N  = 4;
  localparam int FW = 16;
  localparam int DW = 7 + FW;

  typedef logic [N-1:0][IW-1:0] blk_t;
  typedef logic [N-1:0][7:0]    qblk_t;

  typedef struct packed {
    logic [IW-1:0] mx;
    blk_t          x;
    qblk_t         ex;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  blk_t          data_in;
  logic [IW-1:0] max_num;
  logic          data_in_valid;
  logic          data_in_ready;
  qblk_t         data_out;
  logic [IW-1:0] scale_out;
  logic          data_out_valid;
  logic          data_out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  int8_block_quantizer #(
    .IN_WIDTH       (IW),
    .IN_SIZE        (N),
    .IN_PARALLELISM (1),
    .FRAC_WIDTH     (FW),
    .OUT_WIDTH      (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .max_num        (max_num),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .scale_out      (scale_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic blk_t pack4(input int a, input int b, input int c, input int d);
    blk_t r;
    r[0] = IW'(a);
    r[1] = IW'(b);
    r[2] = IW'(c);
    r[3] = IW'(d);
    return r;
  endfunction

  function automatic qblk_t pack8(input int a, input int b, input int c, input int d);
    qblk_t r;
    r[0] = 8'(a);
    r[1] = 8'(b);
    r[2] = 8'(c);
    r[3] = 8'(d);
    return r;
  endfunction

  // Reference: q = sign(x) * min(127, round_or_trunc(|x * floor(127*2^FW/max)| / 2^FW)).
  function automatic int model_q(input int x, input int mx);
    longint recip;
    longint p;
    longint a;
    longint q;
    if (mx == 0) return 0;
    recip = (longint'(127) << FW) / longint'(mx);
    p = longint'(x) * recip;
    a = (p < 0) ? -p : p;
`ifdef INT8_QUANT_ROUND_NEAREST_EN
    q = (a + (longint'(1) << (FW - 1))) >> FW;
`else
    q = a >> FW;
`endif
    if (q > 127) q = 127;
    return (p < 0) ? -int'(q) : int'(q);
  endfunction

  // Called at a negedge with the DUT idle. When release_out is 0 it returns
  // at the negedge where data_out_valid is first seen, leaving the output held.
  task automatic run_block(input string tag, input logic [IW-1:0] mx, input blk_t x,
                           input qblk_t ex, input bit release_out);
    int cyc;
    check({tag, " in_ready_before"}, longint'(data_in_ready), 1);
    max_num       = mx;
    data_in       = x;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1 data_in_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!data_out_valid && cyc < 100);
    check({tag, " latency"}, longint'(cyc), (mx == 0) ? 2 : DW + 2);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s lane%0d", tag, i), longint'($signed(data_out[i])),
            longint'($signed(ex[i])));
    end
    check({tag, " scale_out"}, longint'(scale_out), longint'(mx));
    if (release_out) begin
      @(negedge clk);
      check({tag, " valid_after_hs"}, longint'(data_out_valid), 0);
      check({tag, " in_ready_after_hs"}, longint'(data_in_ready), 1);
    end
  endtask

  vec_t  tbl [5];
  qblk_t snap_q;
  logic [IW-1:0] snap_s;

  initial begin
    rst            = 1'b1;
    data_in        = '0;
    max_num        = '0;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b1;

    // Directed vectors; only expected values depend on the rounding build.
    tbl[0] = '{16'd254,   pack4(254, 1, -127, 0),         '0};
    tbl[1] = '{16'd0,     pack4(0, 0, 0, 0),              pack8(0, 0, 0, 0)};
    tbl[2] = '{16'h8000,  pack4(-32768, 32767, 16384, -1), '0};
    tbl[3] = '{16'd1,     pack4(1, -1, 0, 1),             pack8(127, -127, 0, 127)};
    tbl[4] = '{16'd100,   pack4(300, -300, 100, -100),    '0};
`ifdef INT8_QUANT_ROUND_NEAREST_EN
    tbl[0].ex = pack8(127, 1, -64, 0);
    tbl[2].ex = pack8(-127, 127, 64, 0);
    tbl[4].ex = pack8(127, -127, 127, -127);
`else
    tbl[0].ex = pack8(127, 0, -63, 0);
    tbl[2].ex = pack8(-127, 126, 63, 0);
    tbl[4].ex = pack8(127, -127, 126, -126);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", longint'(data_in_ready), 1);
    check("reset out_valid", longint'(data_out_valid), 0);
    check("reset data_out", longint'(data_out), 0);
    check("reset scale_out", longint'(scale_out), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      run_block($sformatf("tbl%0d", v), tbl[v].mx, tbl[v].x, tbl[v].ex, 1'b1);
    end

    // Backpressure: hold the output for 10 cycles with a competing input offered.
    data_out_ready = 1'b0;
    run_block("bp", tbl[0].mx, tbl[0].x, tbl[0].ex, 1'b0);
    snap_q = data_out;
    snap_s = scale_out;
    max_num       = 16'd1;
    data_in       = pack4(1, 0, -1, 1);
    data_in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d valid", c), longint'(data_out_valid), 1);
      check($sformatf("bp hold%0d data", c), longint'(data_out), longint'(snap_q));
      check($sformatf("bp hold%0d scale", c), longint'(scale_out), longint'(snap_s));
      check($sformatf("bp hold%0d in_ready", c), longint'(data_in_ready), 0);
    end
    data_out_ready = 1'b1;
    @(negedge clk);
    check("bp released valid", longint'(data_out_valid), 0);
    run_block("bp_next", 16'd1, pack4(1, 0, -1, 1), pack8(127, 0, -127, 127), 1'b1);

    // Reset in the middle of a division discards the block.
    max_num       = 16'd254;
    data_in       = tbl[0].x;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1 data_in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst valid", longint'(data_out_valid), 0);
    check("midrst data_out", longint'(data_out), 0);
    check("midrst scale_out", longint'(scale_out), 0);
    check("midrst in_ready", longint'(data_in_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    run_block("post_rst", 16'd1, pack4(1, -1, 0, 1), pack8(127, -127, 0, 127), 1'b1);

    // Randomized blocks against the arithmetic reference.
    for (int k = 0; k < 40; k++) begin
      int            mode;
      int            mxi;
      int            xv;
      logic [IW-1:0] rv;
      blk_t          xb;
      qblk_t         eb;
      mode = int'($urandom_range(0, 9));
      if (mode == 0)      mxi = 0;
      else if (mode == 1) mxi = 32768;
      else                mxi = int'($urandom_range(1, 32768));
      for (int i = 0; i < N; i++) begin
        if (mode == 2) begin
          rv = IW'($urandom());
          xv = int'($signed(rv));
        end else begin
          xv = int'($urandom_range(0, 2 * mxi)) - mxi;
          if (xv > 32767) xv = 32767;
        end
        xb[i] = IW'(xv);
        eb[i] = 8'(model_q(xv, mxi));
      end
      run_block($sformatf("rnd%0d", k), IW'(mxi), xb, eb, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
